// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with runtime frame format.
// Frames leave LSB-first and run back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic [1:0]                      data_bits,
  input  logic [1:0]                      parity_type,
  input  logic                            stop_bits,
  input  logic [7:0]                      s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            data_tx,
  output logic                            active_flag,
  output logic                            done_flag,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e state_q, state_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] level_q, level_d;

  logic [DIV_W-1:0] div_q, cnt_q, cnt_d;
  logic [1:0]       nbits_q;
  logic             par_en_q, pbit_q, stop2_q;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic             scnt_q, scnt_d;
  logic             tx_q, tx_d;
  logic             act_q, act_d;
  logic             done_q;

  logic       push, pop;
  logic       bit_end, last_bit, frame_end;
  logic [7:0] head, head_m;

  assign s_ready    = reset_n & (level_q != FULL);
  assign push       = s_valid & s_ready;
  assign head       = mem_q[rptr_q];
  assign head_m     = head & (8'hFF >> (~data_bits));
  assign bit_end    = (cnt_q == div_q);
  assign last_bit   = (bit_q == {1'b1, nbits_q});
  assign pop        = (level_q != '0) &
                      ((state_q == IDLE) | frame_end);

  assign data_tx     = tx_q;
  assign active_flag = act_q;
  assign done_flag   = done_q;
  assign fifo_level  = level_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level_q != '0) state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && last_bit)
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end && (scnt_q || !stop2_q)) begin
          frame_end = 1'b1;
          state_d   = (level_q != '0) ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    scnt_d = scnt_q;
    if (pop) begin
      cnt_d  = '0;
      sh_d   = head;
      scnt_d = 1'b0;
    end else if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
      if (bit_end) begin
        if (state_q == START) bit_d = '0;
        if (state_q == DATA && !last_bit) begin
          bit_d = bit_q + 3'd1;
          sh_d  = sh_q >> 1;
        end
        if (state_q == STOP) scnt_d = 1'b1;
      end
    end
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = pbit_q;
      default: tx_d = 1'b1;
    endcase
    act_d = (state_d != IDLE);
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + LVL_W'(1);
    else if (pop && !push)
      level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= s_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      div_q    <= '0;
      nbits_q  <= '0;
      par_en_q <= 1'b0;
      pbit_q   <= 1'b0;
      stop2_q  <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      scnt_q   <= 1'b0;
      tx_q     <= 1'b1;
      act_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      level_q <= level_d;
      // Frame format is frozen at pop time.
      if (pop) begin
        div_q    <= baud_div;
        nbits_q  <= data_bits;
        par_en_q <= (parity_type == 2'b01) |
                    (parity_type == 2'b10);
        pbit_q   <= (^head_m) ^ (parity_type == 2'b01);
        stop2_q  <= stop_bits;
      end
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      scnt_q <= scnt_d;
      tx_q   <= tx_d;
      act_q  <= act_d;
      done_q <= frame_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Expected line samples per frame are queued at push time.
module tb_uart_tx_fifo;

  logic        clock;
  logic        reset_n;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [1:0]  parity_type;
  logic        stop_bits;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        data_tx;
  logic        active_flag;
  logic        done_flag;
  logic [2:0]  fifo_level;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;

  typedef struct {
    logic [255:0] s;
    int           n;
  } frame_t;

  frame_t       exp_q [$];
  logic [255:0] cur   = '0;
  int           cur_n = 0;
  int           frm   = 0;

  uart_tx_fifo #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .fifo_level  (fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic frame_t mk(input logic [7:0] b,
                                input int div,
                                input logic [1:0] db,
                                input logic [1:0] pt,
                                input logic sb);
    frame_t f;
    logic   bits [$];
    int     nd   = 5 + int'(db);
    int     ones = 0;
    f.s = '0;
    f.n = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (pt == 2'b01) bits.push_back(~ones[0]);
    if (pt == 2'b10) bits.push_back(ones[0]);
    bits.push_back(1'b1);
    if (sb) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int r = 0; r <= div; r++) begin
        f.s[f.n] = bits[k];
        f.n++;
      end
    end
    return f;
  endfunction

  always @(negedge clock) begin
    frame_t e;
    if (!reset_n) begin
      cur   = '0;
      cur_n = 0;
    end else begin
      if (done_flag) begin
        done_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_unexpected: got %0d samples, required no frame",
                   cur_n);
        end else begin
          e = exp_q.pop_front();
          if (cur_n != e.n || cur !== e.s) begin
            fails++;
            $display("FAIL frame%0d: got len %0d bits %h, required len %0d bits %h",
                     frm, cur_n, cur, e.n, e.s);
          end
        end
        frm++;
        cur   = '0;
        cur_n = 0;
      end
      if (active_flag && cur_n < 256) begin
        cur[cur_n] = data_tx;
        cur_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input int div, input logic [1:0] db,
                         input logic [1:0] pt, input logic sb);
    baud_div    = 16'(div);
    data_bits   = db;
    parity_type = pt;
    stop_bits   = sb;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_it,
                           input int div, input logic [1:0] db,
                           input logic [1:0] pt, input logic sb);
    logic rdy;
    int   c = 0;
    if (expect_it) exp_q.push_back(mk(b, div, db, pt, sb));
    s_data  = b;
    s_valid = 1'b1;
    do begin
      rdy = s_ready;
      tick();
      c++;
    end while (!rdy && c < 2000);
    s_valid = 1'b0;
    tests++;
    if (!rdy) begin
      fails++;
      $display("FAIL push_%h: not accepted in %0d cycles, required accept", b, c);
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d frames pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    tick();
    tests++;
    if (data_tx !== 1'b1 || active_flag !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: tx=%b act=%b, required tx=1 act=0",
               nm, data_tx, active_flag);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    tests++;
    if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0 ||
        fifo_level !== 3'd0 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: tx=%b act=%b done=%b lvl=%0d rdy=%b, required 1 0 0 0 0",
               data_tx, active_flag, done_flag, fifo_level, s_ready);
    end
    reset_n = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 1", s_ready);
    end
    tick();
  endtask

  task automatic test_8n1();
    int d0 = done_cnt;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    push_byte(8'h55, 1'b1, 3, 2'd3, 2'd0, 1'b0);
    tests++;
    if (fifo_level !== 3'd1 || data_tx !== 1'b1 || active_flag !== 1'b0) begin
      fails++;
      $display("FAIL 8n1_after_push: lvl=%0d tx=%b act=%b, required 1 1 0",
               fifo_level, data_tx, active_flag);
    end
    tick();
    tests++;
    if (fifo_level !== 3'd0 || data_tx !== 1'b0 || active_flag !== 1'b1) begin
      fails++;
      $display("FAIL 8n1_start: lvl=%0d tx=%b act=%b, required 0 0 1",
               fifo_level, data_tx, active_flag);
    end
    drain("8n1", 200);
    repeat (5) tick();
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL 8n1_done_count: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_7e2();
    set_cfg(1, 2'd2, 2'd2, 1'b1);
    push_byte(8'h41, 1'b1, 1, 2'd2, 2'd2, 1'b1);
    drain("7e2", 200);
  endtask

  task automatic test_5o1();
    set_cfg(2, 2'd0, 2'd1, 1'b0);
    push_byte(8'hFF, 1'b1, 2, 2'd0, 2'd1, 1'b0);
    drain("5o1", 200);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [8] = '{8'hA5, 8'h5A, 8'h0F, 8'hF0,
                              8'h33, 8'hCC, 8'h81, 8'h7E};
    int exp_acc [8] = '{0, 1, 2, 3, 4, 162, 322, 482};
    int acc [8];
    int n_acc = 0;
    int dn    = 0;
    int lowc  = 0;
    int i     = 0;
    logic rdy;
    set_cfg(15, 2'd3, 2'd0, 1'b0);
    foreach (bytes[j]) exp_q.push_back(mk(bytes[j], 15, 2'd3, 2'd0, 1'b0));
    for (int j = 0; j < 8; j++) acc[j] = -1;
    s_data  = bytes[0];
    s_valid = 1'b1;
    while (dn < 8 && i < 2000) begin
      rdy = s_ready;
      if (i == 5) begin
        tests++;
        if (rdy !== 1'b0) begin
          fails++;
          $display("FAIL bp_full_ready: got %b, required 0", rdy);
        end
      end
      @(negedge clock);
      if (done_flag) dn++;
      if (i >= 2 && dn < 8 && active_flag !== 1'b1) lowc++;
      tick();
      if (rdy && s_valid && n_acc < 8) begin
        acc[n_acc] = i;
        n_acc++;
        if (n_acc == 8) s_valid = 1'b0;
        else s_data = bytes[n_acc];
      end
      i++;
    end
    s_valid = 1'b0;
    tests++;
    if (dn != 8) begin
      fails++;
      $display("FAIL bp_done_pulses: got %0d, required 8", dn);
    end
    tests++;
    if (lowc != 0) begin
      fails++;
      $display("FAIL bp_active_gap: got %0d low cycles, required 0", lowc);
    end
    for (int j = 0; j < 8; j++) begin
      tests++;
      if (acc[j] != exp_acc[j]) begin
        fails++;
        $display("FAIL bp_accept%0d: got cycle %0d, required %0d",
                 j, acc[j], exp_acc[j]);
      end
    end
    drain("bp", 20);
  endtask

  task automatic test_cfg_change();
    int d0 = done_cnt;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    push_byte(8'hC3, 1'b1, 3, 2'd3, 2'd0, 1'b0);
    push_byte(8'h96, 1'b1, 7, 2'd3, 2'd2, 1'b0);
    repeat (10) tick();
    baud_div    = 16'd7;
    parity_type = 2'd2;
    drain("cfg", 600);
    tests++;
    if (done_cnt - d0 != 2) begin
      fails++;
      $display("FAIL cfg_done_count: got %0d, required 2", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0   = done_cnt;
    int busy = 0;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    push_byte(8'h12, 1'b0, 3, 2'd3, 2'd0, 1'b0);
    push_byte(8'h34, 1'b0, 3, 2'd3, 2'd0, 1'b0);
    push_byte(8'h56, 1'b0, 3, 2'd3, 2'd0, 1'b0);
    repeat (6) tick();
    tests++;
    if (fifo_level !== 3'd2 || active_flag !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre: lvl=%0d act=%b, required 2 1", fifo_level, active_flag);
    end
    reset_n = 1'b0;
    tick();
    tests++;
    if (data_tx !== 1'b1 || active_flag !== 1'b0 || fifo_level !== 3'd0 ||
        done_flag !== 1'b0 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: tx=%b act=%b lvl=%0d done=%b rdy=%b, required 1 0 0 0 0",
               data_tx, active_flag, fifo_level, done_flag, s_ready);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) busy++;
    end
    tests++;
    if (busy != 0 || done_cnt != d0) begin
      fails++;
      $display("FAIL rst_quiet: got %0d busy cycles %0d dones, required 0 0",
               busy, done_cnt - d0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter: next generation of the team's fixed-format Tx unit. Accepts bytes over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Baud divisor, data length (5–8), parity and stop-bit count are runtime-selectable. Frames are sent back-to-back while the FIFO is non-empty. It sits between a bus-side producer and the serial pin and pairs with the matching Rx unit.

## Interface

**Parameters**

- `DIV_W`, default 16: width of `baud_div`.
- `FIFO_DEPTH`, default 4: number of FIFO entries. Must be a power of two, ≥ 2.

**Ports**

- `clock` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `baud_div` in DIV_W: clocks per bit minus 1.
- `data_bits` in 2: data length; 00=5, 01=6, 10=7, 11=8.
- `parity_type` in 2: 00 = none, 01 = odd, 10 = even, 11 = none.
- `stop_bits` in 1: 0 = one stop bit, 1 = two stop bits.
- `s_data` in 8: byte to send. Bits above the selected length are ignored.
- `s_valid` in 1: producer has data.
- `s_ready` out 1: FIFO can accept.
- `data_tx` out 1: serial line, registered; idles high.
- `active_flag` out 1: high while a frame is on the line.
- `done_flag` out 1: one-cycle pulse at the end of each frame.
- `fifo_level` out $clog2(FIFO_DEPTH+1): current number of stored entries.

## Operation

- **Reset** (`reset_n` low at an edge): `data_tx`=1, `active_flag`=0, `done_flag`=0, `fifo_level`=0, FSM to IDLE. While `reset_n` is low, writes are ignored and `s_ready`=0. Once out of reset, `s_ready` = (`fifo_level` != FIFO_DEPTH).
- **Push:** occurs on an edge where `s_valid` && `s_ready`. If a push and a pop happen on the same edge, the level is unchanged. There is no bypass: when the FIFO is full, `s_ready`=0 even if a pop happens on that edge.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START: when `fifo_level`>0. On this edge, pop the head entry and latch `baud_div`, `data_bits`, `parity_type` and `stop_bits` into frame registers. Config changes during a frame do not affect it.
  - START: drive 0 for one bit time, then → DATA.
  - DATA: drive `data[i]`, i = 0..N-1, one bit time each. Then → PARITY if parity is enabled, otherwise → STOP.
  - PARITY: one bit time.
    - Even parity: the bit is the XOR of the N data bits.
    - Odd parity: the bit is the inverse of that XOR.
  - STOP: drive 1 for 1 or 2 bit times.
  - End of the last stop bit: pulse `done_flag`. Then → START with a new pop if the FIFO is non-empty (no idle gap), otherwise → IDLE.
- **Bit time:** `baud_div`+1 clocks, using a down/up counter of DIV_W bits. `baud_div`=0 gives 1 clock per bit. There is no overflow: the counter compares against the latched divisor.
- **Frame length** in clocks: (`baud_div`+1)·(1 + N + P + S), where N = 5..8 data bits, P ∈ {0,1} parity bits, S ∈ {1,2} stop bits.
- `active_flag`: high from the first START clock through the last STOP clock. Low in IDLE. Stays continuously high across back-to-back frames.

## Timing

- A push on edge k makes `fifo_level`=1 after edge k.
- If the FSM is in IDLE, it pops on edge k+1. `data_tx` goes to 0 and `active_flag` to 1 after edge k+1.
- Latency from push to start bit on the line: 2 clocks.
- `done_flag` is high for exactly the one cycle following the edge that ends the last stop bit. `data_tx` changes on that same edge: low if the next frame starts, otherwise stays 1.
- `data_tx` changes only on bit-time boundaries, and it is glitch-free because it is a register output.
- Reset mid-frame takes effect on the next edge:
  - the frame is abandoned and the line returns to 1 immediately;
  - no `done_flag` pulse is generated;
  - FIFO contents are discarded.

## Test plan

- **8N1 timing:** `baud_div`=3, `data_bits`=11, `parity_type`=00, `stop_bits`=0, push 0x55. Required: `data_tx` = 0,1,0,1,0,1,0,1,0,1, each held 4 clocks (40 clocks total). Start bit begins 2 clocks after the push. `done_flag` pulses once, then the line idles at 1.
- **7E2 format:** `data_bits`=10, `parity_type`=10, `stop_bits`=1, push 0x41. Required: bits 0 | 1,0,0,0,0,0,1 | parity 0 | 1,1. That is 11 bit times, and the MSB of 0x41 is not sent.
- **5O1 format:** `data_bits`=00, `parity_type`=01, push 0xFF. Required: 0 | 1,1,1,1,1 | parity 0 | 1.
- **Back-pressure:** FIFO_DEPTH=4, `baud_div`=15, `s_valid` held high with 8 distinct bytes. Required:
  - 5 bytes are accepted on consecutive cycles, then `s_ready`=0;
  - from then on, one further byte is accepted per completed frame;
  - all 8 frames are sent in order, back-to-back with no idle bits;
  - `active_flag` stays high throughout and `done_flag` pulses 8 times.
- **Config change mid-frame:** start an 8N1 frame with `baud_div`=3, then set `baud_div`=7 and `parity_type`=10 mid-frame. Required: the current frame completes unchanged; the next frame uses the new settings.
- **Reset mid-frame:** assert `reset_n`=0 for 1 cycle during the DATA state with 2 entries queued. Required: after that edge, `data_tx`=1, `active_flag`=0, `fifo_level`=0 and no `done_flag`. No further frames are sent.
